// File: rtl/phy_tx_lane_scheduler_if.sv
// Lane-side and serializer-side signals of the PHY TX lane scheduler.
// The producer/consumer side takes the master modport; the scheduler takes the slave modport.
interface phy_tx_lane_scheduler_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic              valid0;
  logic              valid1;
  logic              valid2;
  logic              valid3;
  logic [3:0]        ready;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              is_k;
  logic [1:0]        lane_sel;
  logic [3:0]        overflow_err;

  modport master (
    output in0, in1, in2, in3,
    output valid0, valid1, valid2, valid3,
    output out_ready,
    input  ready, data_out, valid_out, is_k, lane_sel, overflow_err
  );

  modport slave (
    input  in0, in1, in2, in3,
    input  valid0, valid1, valid2, valid3,
    input  out_ready,
    output ready, data_out, valid_out, is_k, lane_sel, overflow_err
  );
endinterface

// File: rtl/phy_tx_lane_scheduler.sv
// Four-lane round-robin TX byte scheduler with per-lane FIFOs and a post-reset idle training run.
// Define PHYTX_SKIP_INSERT_EN to insert a SKP K-symbol after every SKIP_INTERVAL data bytes.
module phy_tx_lane_scheduler #(
  parameter int unsigned         DATA_W     = 8,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter int unsigned         TRAIN_LEN  = 4,
  parameter logic [DATA_W-1:0]   IDLE_SYM   = 8'hBC
`ifdef PHYTX_SKIP_INSERT_EN
  ,
  parameter logic [DATA_W-1:0]   SKP_SYM       = 8'h1C,
  parameter int unsigned         SKIP_INTERVAL = 16
`endif
) (
  input logic                    clk,
  input logic                    reset_L,
  phy_tx_lane_scheduler_if.slave bus
);

  localparam int unsigned NumLanes = 4;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned TrainW   = $clog2(TRAIN_LEN + 1);
`ifdef PHYTX_SKIP_INSERT_EN
  localparam int unsigned SkipW    = $clog2(SKIP_INTERVAL + 1);
`endif

`ifdef PHYTX_SKIP_INSERT_EN
  typedef enum logic [1:0] {StTrain, StActive, StSkip} state_e;
`else
  typedef enum logic [1:0] {StTrain, StActive} state_e;
`endif

  logic [DATA_W-1:0]   lane_data  [NumLanes];
  logic [NumLanes-1:0] lane_valid;

  logic [DATA_W-1:0]   mem_q      [NumLanes][FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q   [NumLanes];
  logic [PtrW-1:0]     wr_ptr_d   [NumLanes];
  logic [PtrW-1:0]     rd_ptr_q   [NumLanes];
  logic [PtrW-1:0]     rd_ptr_d   [NumLanes];
  logic [CntW-1:0]     count_q    [NumLanes];
  logic [CntW-1:0]     count_d    [NumLanes];
  logic [NumLanes-1:0] full;
  logic [NumLanes-1:0] empty;
  logic [NumLanes-1:0] push;
  logic [NumLanes-1:0] pop;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [TrainW-1:0]   train_cnt_q, train_cnt_d;
`ifdef PHYTX_SKIP_INSERT_EN
  logic [SkipW-1:0]    skip_cnt_q, skip_cnt_d;
`endif
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic                is_k_q, is_k_d;
  logic [1:0]          lane_sel_q, lane_sel_d;
  logic [NumLanes-1:0] overflow_q, overflow_d;

  logic                sel_found;
  logic [1:0]          sel_lane;
  logic [1:0]          cand;

  assign lane_data[0] = bus.in0;
  assign lane_data[1] = bus.in1;
  assign lane_data[2] = bus.in2;
  assign lane_data[3] = bus.in3;
  assign lane_valid   = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};

  // Ready and push acceptance look only at the registered count, never at a same-cycle pop.
  always_comb begin
    for (int n = 0; n < NumLanes; n++) begin
      full[n]  = (count_q[n] == CntW'(FIFO_DEPTH));
      empty[n] = (count_q[n] == '0);
      push[n]  = lane_valid[n] & ~full[n];
    end
  end

  always_comb begin
    overflow_d = overflow_q | (lane_valid & full);
    for (int n = 0; n < NumLanes; n++) begin
      wr_ptr_d[n] = push[n] ? wr_ptr_q[n] + PtrW'(1) : wr_ptr_q[n];
      rd_ptr_d[n] = pop[n]  ? rd_ptr_q[n] + PtrW'(1) : rd_ptr_q[n];
      count_d[n]  = count_q[n] + CntW'(push[n]) - CntW'(pop[n]);
    end
  end

  // First non-empty lane in scan order ptr, ptr+1, ptr+2, ptr+3.
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = '0;
    cand      = '0;
    for (int i = 0; i < NumLanes; i++) begin
      cand = ptr_q + 2'(i);
      if (!sel_found && !empty[cand]) begin
        sel_found = 1'b1;
        sel_lane  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    train_cnt_d = train_cnt_q;
`ifdef PHYTX_SKIP_INSERT_EN
    skip_cnt_d  = skip_cnt_q;
`endif
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    is_k_d      = is_k_q;
    lane_sel_d  = lane_sel_q;
    pop         = '0;

    if (bus.out_ready) begin
      unique case (state_q)
        StTrain: begin
          data_out_d  = IDLE_SYM;
          valid_out_d = 1'b0;
          is_k_d      = 1'b1;
          train_cnt_d = train_cnt_q + TrainW'(1);
          if (train_cnt_d == TrainW'(TRAIN_LEN)) begin
            state_d = StActive;
          end
        end
        StActive: begin
          if (sel_found) begin
            pop[sel_lane] = 1'b1;
            data_out_d    = mem_q[sel_lane][rd_ptr_q[sel_lane]];
            valid_out_d   = 1'b1;
            is_k_d        = 1'b0;
            lane_sel_d    = sel_lane;
            ptr_d         = sel_lane + 2'd1;
`ifdef PHYTX_SKIP_INSERT_EN
            skip_cnt_d    = skip_cnt_q + SkipW'(1);
            if (skip_cnt_d == SkipW'(SKIP_INTERVAL)) begin
              state_d = StSkip;
            end
`endif
          end else begin
            data_out_d  = IDLE_SYM;
            valid_out_d = 1'b0;
            is_k_d      = 1'b1;
          end
        end
`ifdef PHYTX_SKIP_INSERT_EN
        StSkip: begin
          // SKP consumes an output slot but leaves the FIFOs and ptr untouched.
          data_out_d  = SKP_SYM;
          valid_out_d = 1'b1;
          is_k_d      = 1'b1;
          skip_cnt_d  = '0;
          state_d     = StActive;
        end
`endif
        default: state_d = StTrain;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StTrain;
      ptr_q       <= '0;
      train_cnt_q <= '0;
`ifdef PHYTX_SKIP_INSERT_EN
      skip_cnt_q  <= '0;
`endif
      data_out_q  <= IDLE_SYM;
      valid_out_q <= 1'b0;
      is_k_q      <= 1'b1;
      lane_sel_q  <= '0;
      overflow_q  <= '0;
      for (int n = 0; n < NumLanes; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        count_q[n]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      train_cnt_q <= train_cnt_d;
`ifdef PHYTX_SKIP_INSERT_EN
      skip_cnt_q  <= skip_cnt_d;
`endif
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      is_k_q      <= is_k_d;
      lane_sel_q  <= lane_sel_d;
      overflow_q  <= overflow_d;
      for (int n = 0; n < NumLanes; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
        count_q[n]  <= count_d[n];
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NumLanes; n++) begin
      if (push[n]) begin
        mem_q[n][wr_ptr_q[n]] <= lane_data[n];
      end
    end
  end

  assign bus.ready        = ~full;
  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.is_k         = is_k_q;
  assign bus.lane_sel     = lane_sel_q;
  assign bus.overflow_err = overflow_q;

endmodule

// File: doc/phy_tx_lane_scheduler.md
Name: phy_tx_lane_scheduler

Overview:
- Controller for the PHY TX byte path: takes four 8-bit input lanes (in0..in3, each with its own valid) and serves them round-robin into one registered byte stream (data_out/valid_out).
- Each lane has a small FIFO, so bursts survive downstream stalls.
- After reset, emits a training run of idle K-symbols before any data.
- Sits between the lane producers and the serializer/recirculation stage; runs entirely in the fast clock domain.

Parameters:
- DATA_W, 8, lane and output byte width.
- FIFO_DEPTH, 4, entries per lane FIFO; power of 2, ≥2.
- TRAIN_LEN, 4, idle symbols emitted after reset before data is allowed; ≥1.
- IDLE_SYM, 8'hBC, K-symbol driven when no data is sent.
- SKP_SYM, 8'h1C, skip K-symbol (optional feature only).
- SKIP_INTERVAL, 16, data bytes between skip insertions (optional feature only).

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset_L  in  1  asynchronous, active-low reset.
- in0..in3  in  DATA_W each  lane data.
- valid0..valid3  in  1 each  lane push request.
- ready  out  4  bit N = lane N FIFO not full; combinational from count.
- out_ready  in  1  downstream accepts output this cycle.
- data_out  out  DATA_W  registered output byte.
- valid_out  out  1  data_out carries lane data (or SKP).
- is_k  out  1  data_out is a K-symbol.
- lane_sel  out  2  lane that sourced the current data_out.
- overflow_err  out  4  sticky per-lane dropped-push flag.

Behaviour:
- Reset (reset_L=0), applied asynchronously:
  - data_out=IDLE_SYM, valid_out=0, is_k=1, lane_sel=0, overflow_err=0.
  - All FIFOs emptied, so ready=4'b1111.
  - Round-robin pointer ptr=0; state=S_TRAIN; train/skip counters=0.
  - Reset mid-operation discards all FIFO contents; nothing is replayed.
- Push:
  - Lane N is written when validN && ready[N].
  - If validN && !ready[N], the byte is dropped and overflow_err[N] sets; it clears only on reset.
  - ready reflects count before any same-cycle pop: a full FIFO rejects a push even when it is popped in the same cycle.
  - Simultaneous push and pop on a non-full lane: both happen, count unchanged.
- Stall: when out_ready=0, all outputs, ptr and counters hold and nothing is popped. Pushes continue.
- FSM, advancing only on cycles with out_ready=1:
  - S_TRAIN: drive IDLE_SYM, is_k=1, valid_out=0; increment the train counter. Pushes are accepted, no pops. When the counter reaches TRAIN_LEN, go to S_ACTIVE.
  - S_ACTIVE: scan lanes ptr, ptr+1, ptr+2, ptr+3 (mod 4). Take the first non-empty lane L and pop it. Register data_out=head(L), valid_out=1, is_k=0, lane_sel=L, and set ptr=(L+1) mod 4.
  - S_ACTIVE with all FIFOs empty: data_out=IDLE_SYM, valid_out=0, is_k=1; ptr and lane_sel unchanged.
- Latency: a byte pushed at edge t into an empty FIFO can appear on data_out at edge t+1, given out_ready=1, S_ACTIVE, and the lane being first in scan order.
- Fairness: every non-empty lane is served at least once every 4 output cycles.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- Macro PHYTX_SKIP_INSERT_EN. When defined:
  - A skip counter increments on every output cycle with valid_out=1 and is_k=0.
  - When it reaches SKIP_INTERVAL, the FSM enters S_SKIP for one out_ready cycle: data_out=SKP_SYM, valid_out=1, is_k=1, no pop.
  - The counter then clears and the FSM returns to S_ACTIVE. ptr is unaffected.
- When not defined: no S_SKIP state, no skip counter, SKP_SYM and SKIP_INTERVAL are unused.

Test Plan:
- Reset, TRAIN_LEN=4, out_ready=1, lane0 pushes 8'hFF at cycle 0 → 4 cycles of data_out=8'hBC, is_k=1, valid_out=0; then data_out=8'hFF, lane_sel=0, valid_out=1.
- In S_ACTIVE with ptr=0, one-cycle push of FF/EE/DD/CC on lanes 0-3 → data_out FF, EE, DD, CC on consecutive cycles with lane_sel 0, 1, 2, 3; then 8'hBC, is_k=1.
- Lane2 pushes 8'h77 then 8'h88; after those two bytes drain (ptr=3), lane0 and lane2 push 8'h11 and 8'h22 together → output 77, 88, then 11 (lane 0) before 22 (lane 2).
- out_ready=0 while lane0 pushes 5 bytes 01..05 → outputs frozen; ready[0]=0 after the 4th push; byte 05 dropped and overflow_err=4'b0001; after out_ready=1 the output is 01..04 only.
- reset_L pulsed low while lanes 0-3 hold data → outputs immediately at reset values, ready=4'b1111; after release, TRAIN_LEN idles and no stale bytes.
- With PHYTX_SKIP_INSERT_EN, SKIP_INTERVAL=8, continuous lane0 data → after every 8 data bytes, one cycle of data_out=8'h1C, is_k=1, valid_out=1. Without the macro, the same stimulus gives no 8'h1C.
